frcr_timer_ctrl: RTL

Bus-facing controller for the 64-bit free-running counter timer in the scheduling stage. It exposes the counter to a 32-bit register requester with tear-free 64-bit reads and writes. It sequences counter loads through the timer's write-enable port. It adds a 64-bit compare unit that raises a held interrupt, in one-shot or periodic mode.

---
 rtl/frcr_timer_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/frcr_timer_ctrl.sv
// frcr_timer_ctrl: 32-bit register front end for the 64-bit free-running timer,
// with tear-free counter access, counter load sequencing and a compare interrupt.
module frcr_timer_ctrl (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iREQ,
  output logic        oBUSY,
  input  logic        iRW,
  input  logic [2:0]  iADDR,
  input  logic [31:0] iDATA,
  output logic        oVALID,
  output logic [31:0] oDATA,
  output logic        oTIMER_WR_ENA,
  output logic [63:0] oTIMER_COUNTER,
  input  logic [63:0] iTIMER_COUNTER,
  output logic        oIRQ,
  input  logic        iIRQ_ACK
);
  typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;

  state_t      state_q, state_d;
  logic [31:0] wr_shadow_q, wr_shadow_d, rd_shadow_q, rd_shadow_d;
  logic [31:0] cmp_shadow_q, cmp_shadow_d, period_q, period_d;
  logic [63:0] compare_q, compare_d, tcnt_q, tcnt_d;
  logic        enable_q, enable_d, periodic_q, periodic_d, pending_q, pending_d;
  logic        valid_q, valid_d, wr_ena_q, wr_ena_d;
  logic [31:0] data_q, data_d, rdata;
  logic        accept, wr, rd, cmp_hi_wr, match, fire;

  // The commit strobe cycle doubles as the busy cycle.
  assign accept    = iREQ && !wr_ena_q;
  assign wr        = accept && iRW;
  assign rd        = accept && !iRW;
  assign cmp_hi_wr = wr && iADDR == 3'd3;
  assign match     = state_q == ARMED && enable_q && iTIMER_COUNTER >= compare_q;
  assign fire      = match && !cmp_hi_wr;

  always_comb begin
    rdata = '0;
    case (iADDR)
      3'd0: rdata = iTIMER_COUNTER[31:0];
      3'd1: rdata = rd_shadow_q;
      3'd2: rdata = compare_q[31:0];
      3'd3: rdata = compare_q[63:32];
      3'd4: rdata = {29'b0, pending_q, periodic_q, enable_q};
      3'd5: rdata = period_q;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_d      = cmp_hi_wr ? ARMED : (fire && !periodic_q) ? FIRED : state_q;
    compare_d    = cmp_hi_wr ? {iDATA, cmp_shadow_q}
                 : (fire && periodic_q) ? compare_q + {32'b0, period_q} : compare_q;
    pending_d    = fire || (pending_q && !iIRQ_ACK);
    wr_shadow_d  = (wr && iADDR == 3'd0) ? iDATA : wr_shadow_q;
    rd_shadow_d  = (rd && iADDR == 3'd0) ? iTIMER_COUNTER[63:32] : rd_shadow_q;
    cmp_shadow_d = (wr && iADDR == 3'd2) ? iDATA : cmp_shadow_q;
    enable_d     = (wr && iADDR == 3'd4) ? iDATA[0] : enable_q;
    periodic_d   = (wr && iADDR == 3'd4) ? iDATA[1] : periodic_q;
    period_d     = (wr && iADDR == 3'd5) ? iDATA : period_q;
    wr_ena_d     = wr && iADDR == 3'd1;
    tcnt_d       = wr_ena_d ? {iDATA, wr_shadow_q} : tcnt_q;
    valid_d      = accept;
    data_d       = rd ? rdata : '0;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q      <= IDLE;
      compare_q    <= '0;
      pending_q    <= 1'b0;
      wr_shadow_q  <= '0;
      rd_shadow_q  <= '0;
      cmp_shadow_q <= '0;
      enable_q     <= 1'b0;
      periodic_q   <= 1'b0;
      period_q     <= '0;
      wr_ena_q     <= 1'b0;
      tcnt_q       <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      compare_q    <= compare_d;
      pending_q    <= pending_d;
      wr_shadow_q  <= wr_shadow_d;
      rd_shadow_q  <= rd_shadow_d;
      cmp_shadow_q <= cmp_shadow_d;
      enable_q     <= enable_d;
      periodic_q   <= periodic_d;
      period_q     <= period_d;
      wr_ena_q     <= wr_ena_d;
      tcnt_q       <= tcnt_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
    end
  end

  assign oBUSY          = wr_ena_q;
  assign oVALID         = valid_q;
  assign oDATA          = data_q;
  assign oTIMER_WR_ENA  = wr_ena_q;
  assign oTIMER_COUNTER = tcnt_q;
  assign oIRQ           = pending_q;
endmodule
